// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   NumSrc     : number of requesting sources
//   IdxW       : width of a source index
//   state_e    : arbiter state encoding (StIdle = 0, StOwned = 1)
//   idx2onehot : binary source index -> one-hot grant vector
package rr_mux_arbiter_pkg;

  localparam int unsigned NumSrc = 4;
  localparam int unsigned IdxW   = 2;

  typedef enum logic {
    StIdle  = 1'b0,
    StOwned = 1'b1
  } state_e;

  function automatic logic [NumSrc-1:0] idx2onehot(input logic [IdxW-1:0] idx);
    logic [NumSrc-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin search.
//   req_i   : request vector, bit k = source k
//   start_i : index where the search begins (wraps 3 -> 0)
//   excl_i  : sources removed from the search
//   found_o : some non-excluded source is requesting
//   idx_o   : first requesting source at or after start_i
module rr_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [NumSrc-1:0] req_i,
  input  logic [IdxW-1:0]   start_i,
  input  logic [NumSrc-1:0] excl_i,
  output logic              found_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [NumSrc-1:0] cand;
  logic              hit;
  logic [IdxW-1:0]   hit_idx;

  assign cand = req_i & ~excl_i;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    // Index arithmetic is IdxW bits wide, so start_i + off wraps naturally.
    for (int unsigned off = 0; off < NumSrc; off++) begin
      if (!hit && cand[start_i + IdxW'(off)]) begin
        hit     = 1'b1;
        hit_idx = start_i + IdxW'(off);
      end
    end
  end

  assign found_o = hit;
  assign idx_o   = hit_idx;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-source round-robin arbiter driving a 4:1 single-bit data mux.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   req    : request per source
//   done   : current owner releases the grant
//   I      : data bit per source
//   grant  : one-hot current owner (registered), zero when idle
//   select : binary index of current owner (registered)
//   valid  : a grant is held (registered)
//   O      : I[select] while valid, else 0
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NumSrc-1:0] req,
  input  logic              done,
  input  logic [NumSrc-1:0] I,
  output logic [NumSrc-1:0] grant,
  output logic [IdxW-1:0]   select,
  output logic              valid,
  output logic              O
);

  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   sel_q, sel_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [7:0]        hold_q, hold_d;
  logic [NumSrc-1:0] grant_q, grant_d;

  logic              pick_found;
  logic [IdxW-1:0]   pick_idx;
  logic [NumSrc-1:0] pick_excl;
  logic              owner_req;
  logic              timeout;
  logic              release_own;

  // While owned, the current owner is kept out of the search so a release
  // hands over to someone else whenever possible.
  assign pick_excl = (state_q == StOwned) ? idx2onehot(sel_q) : '0;

  rr_pick u_pick (
    .req_i   (req),
    .start_i (last_q + 2'd1),
    .excl_i  (pick_excl),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign owner_req   = req[sel_q];
  assign timeout     = (hold_q == HoldLast);
  assign release_own = done | ~owner_req | timeout;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StOwned;
          sel_d   = pick_idx;
          last_d  = pick_idx;
          hold_d  = '0;
          grant_d = idx2onehot(pick_idx);
        end
      end
      StOwned: begin
        if (!release_own) begin
          hold_d = hold_q + 8'd1;
        end else if (pick_found) begin
          sel_d   = pick_idx;
          last_d  = pick_idx;
          hold_d  = '0;
          grant_d = idx2onehot(pick_idx);
        end else if (owner_req && !done && timeout) begin
          // Timeout with nobody else waiting: owner keeps the grant afresh.
          last_d = sel_q;
          hold_d = '0;
        end else begin
          state_d = StIdle;
          sel_d   = '0;
          hold_d  = '0;
          grant_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      last_q  <= 2'd3;
      hold_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
    end
  end

  assign grant  = grant_q;
  assign select = sel_q;
  assign valid  = (state_q == StOwned);

  assign O = (valid & (sel_q == 2'd0) & I[0]) |
             (valid & (sel_q == 2'd1) & I[1]) |
             (valid & (sel_q == 2'd2) & I[2]) |
             (valid & (sel_q == 2'd3) & I[3]);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: per-cycle vector table with a
// scoreboard queue, plus hand sequences for reset behaviour.
module tb_rr_mux_arbiter;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] data;
    logic [3:0] exp_grant;
    logic       exp_valid;
    logic       exp_o;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic       valid;
    logic       o;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] data_in;
  logic [3:0] grant;
  logic [1:0] select;
  logic       valid;
  logic       o_out;

  int checks;
  int errors;

  vec_t vecs[$];
  exp_t sb_q[$];

  rr_mux_arbiter #(
    .HOLD_MAX (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .done   (done),
    .I      (data_in),
    .grant  (grant),
    .select (select),
    .valid  (valid),
    .O      (o_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) if (oh[k]) idx = 2'(k);
    return idx;
  endfunction

  task automatic add(input logic [3:0] r, input logic d, input logic [3:0] dat,
                     input logic [3:0] g, input logic v, input logic o, input int n);
    vec_t e;
    e.req = r; e.done = d; e.data = dat; e.exp_grant = g; e.exp_valid = v; e.exp_o = o;
    for (int k = 0; k < n; k++) vecs.push_back(e);
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // pop and compare just after the edge.
  task automatic step(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    req     = v.req;
    done    = v.done;
    data_in = v.data;
    e.grant = v.exp_grant;
    e.valid = v.exp_valid;
    e.o     = v.exp_o;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({name, " grant"}, 32'(grant), 32'(e.grant));
    chk({name, " valid"}, 32'(valid), 32'(e.valid));
    chk({name, " O"}, 32'(o_out), 32'(e.o));
    if (e.valid) chk({name, " select"}, 32'(select), 32'(oh2idx(e.grant)));
  endtask

  initial begin
    vec_t hv;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    req     = '0;
    done    = 1'b0;
    data_in = '0;

    // Full round-robin rotation, done one cycle after each grant.
    add(4'b1111, 1'b0, 4'b1010, 4'b0001, 1'b1, 1'b0, 1);
    add(4'b1111, 1'b1, 4'b1010, 4'b0010, 1'b1, 1'b1, 1);
    add(4'b1111, 1'b1, 4'b1010, 4'b0100, 1'b1, 1'b0, 1);
    add(4'b1111, 1'b1, 4'b1010, 4'b1000, 1'b1, 1'b1, 1);
    add(4'b1111, 1'b1, 4'b1010, 4'b0001, 1'b1, 1'b0, 1);
    // Owner drops request -> idle; done while idle is ignored; regrant source 0.
    add(4'b0000, 1'b0, 4'b1010, 4'b0000, 1'b0, 1'b0, 1);
    add(4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 2);
    add(4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1);
    add(4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1);
    // Lone requester 2: timeout re-grant with no gap, no pre-emption by
    // source 0, then hand-over to 0 on the second timeout.
    add(4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 11);
    add(4'b0101, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 5);
    add(4'b0101, 1'b0, 4'b0100, 4'b0001, 1'b1, 1'b0, 1);
    // Owner 1 with req 1011: timeout passes to 3, counter restarts, then to 0.
    add(4'b0010, 1'b1, 4'b1010, 4'b0010, 1'b1, 1'b1, 1);
    add(4'b1011, 1'b0, 4'b1010, 4'b0010, 1'b1, 1'b1, 7);
    add(4'b1011, 1'b0, 4'b1010, 4'b1000, 1'b1, 1'b1, 1);
    add(4'b1011, 1'b0, 4'b1010, 4'b1000, 1'b1, 1'b1, 7);
    add(4'b1011, 1'b0, 4'b1010, 4'b0001, 1'b1, 1'b0, 1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset valid", 32'(valid), 32'h0);
    chk("reset select", 32'(select), 32'h0);
    chk("reset O", 32'(o_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Hand over to source 2, then reset in the middle of the cycle.
    hv.req = 4'b0100; hv.done = 1'b1; hv.data = 4'b0100;
    hv.exp_grant = 4'b0100; hv.exp_valid = 1'b1; hv.exp_o = 1'b1;
    step(hv, "owner2");
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst grant", 32'(grant), 32'h0);
    chk("async rst valid", 32'(valid), 32'h0);
    chk("async rst O", 32'(o_out), 32'h0);
    @(negedge clk);
    req = 4'b1111;
    done = 1'b0;
    @(posedge clk);
    #1;
    chk("held rst valid", 32'(valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post rst no early grant", 32'(valid), 32'h0);
    @(posedge clk);
    #1;
    chk("post rst grant", 32'(grant), 32'b0001);
    chk("post rst select", 32'(select), 32'h0);
    chk("post rst O", 32'(o_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum consecutive cycles one requester SHALL hold the grant (legal range 2..255).
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request per source; bit k = source k.
REQ-005 done  input  1  current owner releases the grant this cycle.
REQ-006 I  input  4  data bit per source; bit k = source k.
REQ-007 grant  output  4  one-hot current owner, registered; all-zero when idle.
REQ-008 select  output  2  binary index of current owner, registered; drives 4:1 selection.
REQ-009 valid  output  1  high while a grant is held, registered.
REQ-010 O  output  1  I[select] when valid is high, else 0; combinational from registered select/valid.

Function
REQ-011 The block SHALL have two states, IDLE (valid=0) and OWNED (valid=1).
REQ-012 IDLE: if any req bit is high at a rising edge, the block SHALL enter OWNED at that edge; grant latency is one cycle.
REQ-013 Winner selection SHALL be round-robin: search starts at index (last+1) mod 4, wrapping 3->0; last = most recently granted index.
REQ-014 OWNED: hold counter SHALL increment by 1 each cycle; it is cleared on every new grant.
REQ-015 Release condition: done=1, or req[select]=0, or hold counter = HOLD_MAX-1.
REQ-016 On release, if any other req bit is high, the next round-robin winner SHALL be granted at the same edge (no idle gap); the owner is excluded from that search.
REQ-017 On release with no other request pending, the block SHALL re-grant the same owner if its req is still high and the release was by timeout only; otherwise it SHALL enter IDLE.
REQ-018 On every grant, last SHALL be updated to the winning index.
REQ-019 grant SHALL always equal one-hot(select) when valid=1 and 4'b0000 when valid=0.
REQ-020 done while valid=0 SHALL be ignored.
REQ-021 Requests arriving mid-ownership SHALL NOT pre-empt the owner before a release condition.
REQ-022 Hold counter width SHALL be 8 bits; no wrap occurs since release fires at HOLD_MAX-1.

Reset
REQ-023 rst_n low SHALL immediately force: state IDLE, grant=0, select=0, valid=0, O=0, hold counter=0, last=3 (so source 0 has first priority).
REQ-024 Reset asserted mid-ownership SHALL drop the grant without waiting for a clock edge.
REQ-025 After deassertion, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-026 A shared package SHALL hold state encoding (IDLE=0, OWNED=1), source count 4 and index width 2.
REQ-027 A single sub-module rr_pick SHALL be used: combinational, inputs req[3:0], start index[1:0], exclude-mask[3:0]; outputs found and index[1:0].
REQ-028 The 4:1 output selection SHALL be written in sum-of-products form inside rr_mux_arbiter; no additional sub-modules.

Verification
REQ-029 Reset, then req=4'b1111 held, done pulsed 1 cycle after each grant -> select sequence 0,1,2,3,0; valid stays 1.
REQ-030 req=4'b0100 only, I=4'b0100, never done -> grant=4'b0100, O=1; re-grant to 2 after HOLD_MAX=8 cycles with no idle gap.
REQ-031 Owner 1 holding, req=4'b1011, counter reaches 7 -> next edge grant=4'b1000 (source 3), counter cleared.
REQ-032 Owner 0 drops req with req=4'b0000 -> next edge valid=0, grant=0, O=0; next req=4'b0001 -> grant source 0 after one cycle.
REQ-033 rst_n pulsed low mid-cycle while owner=2 -> grant, valid, O go 0 asynchronously; after release req=4'b1111 -> first grant source 0.
REQ-034 done=1 while IDLE with req=0 -> no state change, all outputs remain 0.
